// File: rtl/text_cmd_decoder.sv
// Byte-stream text console decoder: turns uart bytes into screen-buffer
// cell writes, tracks the cursor and runs a hardware clear-screen sweep.
module text_cmd_decoder #(
  parameter int                  N_COL        = 160,
  parameter int                  N_ROW        = 60,
  parameter int                  COL_WIDTH    = 8,
  parameter int                  ROW_WIDTH    = 6,
  parameter int                  DATA_WIDTH   = 8,
  parameter int                  CHAR_WIDTH   = 7,
  parameter int                  ATTR_WIDTH   = 8,
  parameter logic [ATTR_WIDTH-1:0] ATTR_DEFAULT = 8'h0F,
  parameter logic [CHAR_WIDTH-1:0] CLEAR_CHAR   = 7'h20
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_valid_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  output logic                  wr_en_o,
  output logic [COL_WIDTH-1:0]  col_o,
  output logic [ROW_WIDTH-1:0]  row_o,
  output logic [CHAR_WIDTH-1:0] char_o,
  output logic [ATTR_WIDTH-1:0] attr_o,
  output logic [COL_WIDTH-1:0]  cursor_col_o,
  output logic [ROW_WIDTH-1:0]  cursor_row_o,
  output logic                  busy_o,
  output logic                  drop_o
);

  typedef enum logic [2:0] {
    IDLE, ESC_COL, ESC_ROW, ATTR, CLEAR
  } state_t;

  localparam logic [COL_WIDTH-1:0] COL_MAX = COL_WIDTH'(N_COL - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_MAX = ROW_WIDTH'(N_ROW - 1);
  localparam logic [COL_WIDTH-1:0] COL_ONE = COL_WIDTH'(1);
  localparam logic [ROW_WIDTH-1:0] ROW_ONE = ROW_WIDTH'(1);

  state_t                  state;
  logic                    prev_valid;
  logic [ATTR_WIDTH-1:0]   attr_q;
  logic                    accept;
  logic                    is_print;
  logic                    is_cr;
  logic                    is_lf;
  logic                    is_bs;
  logic                    is_esc;
  logic                    is_attr;
  logic                    is_ff;
  logic [ROW_WIDTH-1:0]    row_next;
  logic [COL_WIDTH-1:0]    col_set;
  logic [ROW_WIDTH-1:0]    row_set;

  assign accept   = rx_valid_i & ~prev_valid;
  assign is_print = (rx_data_i >= DATA_WIDTH'(8'h20)) &&
                    (rx_data_i <= DATA_WIDTH'(8'h7E));
  assign is_cr    = rx_data_i == DATA_WIDTH'(8'h0D);
  assign is_lf    = rx_data_i == DATA_WIDTH'(8'h0A);
  assign is_bs    = rx_data_i == DATA_WIDTH'(8'h08);
  assign is_esc   = rx_data_i == DATA_WIDTH'(8'h1B);
  assign is_attr  = rx_data_i == DATA_WIDTH'(8'h11);
  assign is_ff    = rx_data_i == DATA_WIDTH'(8'h0C);

  // Grid sizes are not powers of two, so every wrap and clamp is explicit
  assign row_next = (cursor_row_o == ROW_MAX) ? '0 : cursor_row_o + ROW_ONE;
  assign col_set  = (32'(rx_data_i) >= N_COL) ? COL_MAX
                                             : COL_WIDTH'(rx_data_i);
  assign row_set  = (32'(rx_data_i) >= N_ROW) ? ROW_MAX
                                             : ROW_WIDTH'(rx_data_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      prev_valid   <= 1'b1;
      attr_q       <= ATTR_DEFAULT;
      wr_en_o      <= 1'b0;
      col_o        <= '0;
      row_o        <= '0;
      char_o       <= '0;
      attr_o       <= '0;
      cursor_col_o <= '0;
      cursor_row_o <= '0;
      busy_o       <= 1'b0;
      drop_o       <= 1'b0;
    end else begin
      prev_valid <= rx_valid_i;
      wr_en_o    <= 1'b0;
      drop_o     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_print: begin
                wr_en_o <= 1'b1;
                col_o   <= cursor_col_o;
                row_o   <= cursor_row_o;
                char_o  <= rx_data_i[CHAR_WIDTH-1:0];
                attr_o  <= attr_q;
                if (cursor_col_o == COL_MAX) begin
                  cursor_col_o <= '0;
                  cursor_row_o <= row_next;
                end else begin
                  cursor_col_o <= cursor_col_o + COL_ONE;
                end
              end
              is_cr: cursor_col_o <= '0;
              is_lf: begin
                cursor_col_o <= '0;
                cursor_row_o <= row_next;
              end
              is_bs: begin
                if (cursor_col_o != '0)
                  cursor_col_o <= cursor_col_o - COL_ONE;
              end
              is_esc:  state <= ESC_COL;
              is_attr: state <= ATTR;
              is_ff: begin
                // first sweep cell is emitted in the same cycle as entry
                state   <= CLEAR;
                busy_o  <= 1'b1;
                wr_en_o <= 1'b1;
                col_o   <= '0;
                row_o   <= '0;
                char_o  <= CLEAR_CHAR;
                attr_o  <= attr_q;
              end
              default: ;
            endcase
          end
        end
        ESC_COL: begin
          if (accept) begin
            cursor_col_o <= col_set;
            state        <= ESC_ROW;
          end
        end
        ESC_ROW: begin
          if (accept) begin
            cursor_row_o <= row_set;
            state        <= IDLE;
          end
        end
        ATTR: begin
          if (accept) begin
            attr_q <= rx_data_i[ATTR_WIDTH-1:0];
            state  <= IDLE;
          end
        end
        CLEAR: begin
          if (accept)
            drop_o <= 1'b1;
          if (col_o == COL_MAX && row_o == ROW_MAX) begin
            busy_o       <= 1'b0;
            cursor_col_o <= '0;
            cursor_row_o <= '0;
            state        <= IDLE;
          end else begin
            wr_en_o <= 1'b1;
            if (col_o == COL_MAX) begin
              col_o <= '0;
              row_o <= row_o + ROW_ONE;
            end else begin
              col_o <= col_o + COL_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_cmd_decoder.sv
// Directed bench for text_cmd_decoder: text, escapes, attributes,
// clear sweep with drop, strobe hold and cursor control codes.
module tb_text_cmd_decoder;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [7:0] col;
  logic [5:0] row;
  logic [6:0] chr;
  logic [7:0] attr;
  logic [7:0] cur_col;
  logic [5:0] cur_row;
  logic       busy;
  logic       drop;

  int tests;
  int fails;
  int wr_total;

  text_cmd_decoder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .wr_en_o      (wr_en),
    .col_o        (col),
    .row_o        (row),
    .char_o       (chr),
    .attr_o       (attr),
    .cursor_col_o (cur_col),
    .cursor_row_o (cur_row),
    .busy_o       (busy),
    .drop_o       (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (wr_en === 1'b1) wr_total++;

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // returns on the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({wr_en, col, row, chr, attr} !== 30'd0) begin
      fails++;
      $display("FAIL reset_fields: got %h want 0",
               {wr_en, col, row, chr, attr});
    end
    tests++;
    if ({cur_col, cur_row, busy, drop} !== 16'd0) begin
      fails++;
      $display("FAIL reset_cursor: got %h want 0",
               {cur_col, cur_row, busy, drop});
    end
  endtask

  task automatic test_text();
    send_byte(8'h41);
    tests++;
    if ({wr_en, col, row, chr, attr} !==
        {1'b1, 8'd0, 6'd0, 7'h41, 8'h0F}) begin
      fails++;
      $display("FAIL text_A: got %h want %h", {wr_en, col, row, chr, attr},
               {1'b1, 8'd0, 6'd0, 7'h41, 8'h0F});
    end
    send_byte(8'h42);
    tests++;
    if ({wr_en, col, row, chr, attr} !==
        {1'b1, 8'd1, 6'd0, 7'h42, 8'h0F}) begin
      fails++;
      $display("FAIL text_B: got %h want %h", {wr_en, col, row, chr, attr},
               {1'b1, 8'd1, 6'd0, 7'h42, 8'h0F});
    end
    tests++;
    if ({cur_col, cur_row} !== {8'd2, 6'd0}) begin
      fails++;
      $display("FAIL text_cursor: got %0d,%0d want 2,0", cur_col, cur_row);
    end
  endtask

  task automatic test_esc();
    send_byte(8'h1B);
    send_byte(8'd159);
    send_byte(8'd5);
    send_byte(8'h78);
    tests++;
    if ({wr_en, col, row, chr, attr} !==
        {1'b1, 8'd159, 6'd5, 7'h78, 8'h0F}) begin
      fails++;
      $display("FAIL esc_write: got %h want %h", {wr_en, col, row, chr, attr},
               {1'b1, 8'd159, 6'd5, 7'h78, 8'h0F});
    end
    tests++;
    if ({cur_col, cur_row} !== {8'd0, 6'd6}) begin
      fails++;
      $display("FAIL esc_wrap: got %0d,%0d want 0,6", cur_col, cur_row);
    end
    send_byte(8'h1B);
    send_byte(8'd200);
    send_byte(8'd99);
    tests++;
    if ({cur_col, cur_row} !== {8'd159, 6'd59}) begin
      fails++;
      $display("FAIL esc_clamp: got %0d,%0d want 159,59", cur_col, cur_row);
    end
    send_byte(8'h79);
    tests++;
    if ({wr_en, col, row, chr} !== {1'b1, 8'd159, 6'd59, 7'h79}) begin
      fails++;
      $display("FAIL esc_corner: got %h want %h", {wr_en, col, row, chr},
               {1'b1, 8'd159, 6'd59, 7'h79});
    end
    tests++;
    if ({cur_col, cur_row} !== {8'd0, 6'd0}) begin
      fails++;
      $display("FAIL esc_corner_wrap: got %0d,%0d want 0,0", cur_col, cur_row);
    end
  endtask

  task automatic test_attr_clear();
    int n_wr;
    int n_drop;
    int n_bad;
    int n_cur;
    logic [7:0] last_col;
    logic [5:0] last_row;
    bit done;
    send_byte(8'h11);
    send_byte(8'h1E);
    send_byte(8'h7A);
    tests++;
    if ({wr_en, col, row, chr, attr} !==
        {1'b1, 8'd0, 6'd0, 7'h7A, 8'h1E}) begin
      fails++;
      $display("FAIL attr_write: got %h want %h", {wr_en, col, row, chr, attr},
               {1'b1, 8'd0, 6'd0, 7'h7A, 8'h1E});
    end
    send_byte(8'h0C);
    tests++;
    if ({busy, wr_en, col, row, chr} !==
        {1'b1, 1'b1, 8'd0, 6'd0, 7'h20}) begin
      fails++;
      $display("FAIL clear_start: got %h want %h", {busy, wr_en, col, row, chr},
               {1'b1, 1'b1, 8'd0, 6'd0, 7'h20});
    end
    n_wr = 0; n_drop = 0; n_bad = 0; n_cur = 0;
    last_col = '0; last_row = '0; done = 1'b0;
    for (int i = 0; i < 10000 && !done; i++) begin
      if (busy !== 1'b1) begin
        done = 1'b1;
      end else begin
        if (wr_en === 1'b1) begin
          n_wr++;
          last_col = col;
          last_row = row;
          if (chr !== 7'h20 || attr !== 8'h1E) n_bad++;
        end
        if (drop === 1'b1) n_drop++;
        if ({cur_col, cur_row} !== {8'd1, 6'd0}) n_cur++;
        if (i == 100) begin
          rx_valid = 1'b1;
          rx_data  = 8'h4B;
        end
        if (i == 101) rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL clear_timeout: busy still %b after 10000 cycles", busy);
    end
    tests++;
    if (n_wr != 9600) begin
      fails++;
      $display("FAIL clear_count: got %0d want 9600", n_wr);
    end
    tests++;
    if ({last_col, last_row} !== {8'd159, 6'd59}) begin
      fails++;
      $display("FAIL clear_last: got %0d,%0d want 159,59", last_col, last_row);
    end
    tests++;
    if (n_bad != 0 || n_cur != 0) begin
      fails++;
      $display("FAIL clear_cells: got %0d bad cells %0d cursor moves want 0",
               n_bad, n_cur);
    end
    tests++;
    if (n_drop != 1) begin
      fails++;
      $display("FAIL clear_drop: got %0d pulses want 1", n_drop);
    end
    tests++;
    if ({busy, wr_en, cur_col, cur_row} !== {1'b0, 1'b0, 8'd0, 6'd0}) begin
      fails++;
      $display("FAIL clear_end: got %h want 0", {busy, wr_en, cur_col, cur_row});
    end
  endtask

  task automatic test_hold();
    int base;
    repeat (3) @(negedge clk);
    base = wr_total;
    rx_valid = 1'b1;
    rx_data  = 8'h51;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (wr_total - base != 1) begin
      fails++;
      $display("FAIL hold_one_write: got %0d want 1", wr_total - base);
    end
    tests++;
    if ({chr, cur_col, cur_row} !== {7'h51, 8'd1, 6'd0}) begin
      fails++;
      $display("FAIL hold_cursor: got %h want %h", {chr, cur_col, cur_row},
               {7'h51, 8'd1, 6'd0});
    end
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h52;
    repeat (2) @(negedge clk);
    base = wr_total;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (wr_total - base != 0 || {cur_col, cur_row} !== 14'd0) begin
      fails++;
      $display("FAIL reset_held_strobe: got %0d writes cursor %0d,%0d want 0",
               wr_total - base, cur_col, cur_row);
    end
  endtask

  task automatic test_cursor();
    int base;
    send_byte(8'h1B);
    send_byte(8'd10);
    send_byte(8'd3);
    repeat (2) @(negedge clk);
    base = wr_total;
    send_byte(8'h08);
    tests++;
    if ({cur_col, cur_row} !== {8'd9, 6'd3}) begin
      fails++;
      $display("FAIL bs: got %0d,%0d want 9,3", cur_col, cur_row);
    end
    send_byte(8'h0D);
    tests++;
    if ({cur_col, cur_row} !== {8'd0, 6'd3}) begin
      fails++;
      $display("FAIL cr: got %0d,%0d want 0,3", cur_col, cur_row);
    end
    send_byte(8'h08);
    tests++;
    if ({cur_col, cur_row} !== {8'd0, 6'd3}) begin
      fails++;
      $display("FAIL bs_at_zero: got %0d,%0d want 0,3", cur_col, cur_row);
    end
    send_byte(8'h0A);
    tests++;
    if ({cur_col, cur_row} !== {8'd0, 6'd4}) begin
      fails++;
      $display("FAIL lf: got %0d,%0d want 0,4", cur_col, cur_row);
    end
    send_byte(8'h1B);
    send_byte(8'd5);
    send_byte(8'd59);
    send_byte(8'h0A);
    tests++;
    if ({cur_col, cur_row} !== {8'd0, 6'd0}) begin
      fails++;
      $display("FAIL lf_wrap: got %0d,%0d want 0,0", cur_col, cur_row);
    end
    send_byte(8'h07);
    repeat (2) @(negedge clk);
    tests++;
    if (wr_total - base != 0 || drop !== 1'b0) begin
      fail_note(wr_total - base);
    end
  endtask

  task automatic fail_note(input int n);
    fails++;
    $display("FAIL ctrl_no_write: got %0d writes drop %b want 0", n, drop);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h11);
    send_byte(8'h2A);
    send_byte(8'h0C);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy, wr_en, col, row, cur_col, cur_row} !== 30'd0) begin
      fails++;
      $display("FAIL reset_mid_clear: got %h want 0",
               {busy, wr_en, col, row, cur_col, cur_row});
    end
    send_byte(8'h1B);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h41);
    tests++;
    if ({wr_en, col, row, chr, attr} !==
        {1'b1, 8'd0, 6'd0, 7'h41, 8'h0F}) begin
      fails++;
      $display("FAIL reset_mid_esc: got %h want %h", {wr_en, col, row, chr, attr},
               {1'b1, 8'd0, 6'd0, 7'h41, 8'h0F});
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    wr_total = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_text();
    test_esc();
    test_attr_clear();
    test_hold();
    test_cursor();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
